// File: rtl/addr4u_pkg.sv
// Shared types and helpers for the nibble-serial redundant adder sequencer.
package addr4u_pkg;

  // Width of one adder slice.
  localparam int NIBBLE_W = 4;

  // Sequencer states: idle, first execution (a+b), second execution (b+a), result held.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed to count 0..max_retry, never less than one.
  function automatic int retry_w(input int max_retry);
    int w;
    w = $clog2(max_retry + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/addr4u_nibble_mux.sv
// Picks the active nibble of both operands and presents them to the adder slice,
// swapping the operand order on the second (redundant) execution.
module addr4u_nibble_mux
  import addr4u_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int IW      = 2
) (
  input  logic [NIBBLES*NIBBLE_W-1:0] a,
  input  logic [NIBBLES*NIBBLE_W-1:0] b,
  input  logic [IW-1:0]               idx,
  input  logic                        swap,
  input  logic                        en,
  output logic [NIBBLE_W-1:0]         add_a,
  output logic [NIBBLE_W-1:0]         add_b
);

  logic [NIBBLE_W-1:0] nib_a [NIBBLES];
  logic [NIBBLE_W-1:0] nib_b [NIBBLES];
  logic [NIBBLE_W-1:0] sel_a;
  logic [NIBBLE_W-1:0] sel_b;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_split
      assign nib_a[gi] = a[gi*NIBBLE_W +: NIBBLE_W];
      assign nib_b[gi] = b[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  // Select nibble idx, then swap and gate so the slice sees zeros when idle.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        sel_a = nib_a[i];
        sel_b = nib_b[i];
      end
    end
    add_a = '0;
    add_b = '0;
    if (en) begin
      add_a = swap ? sel_b : sel_a;
      add_b = swap ? sel_a : sel_b;
    end
  end

endmodule

// File: rtl/addr4u_nibble_seq.sv
// Wide unsigned adder built from one shared 4-bit slice: each nibble is computed
// twice (a+b then b+a), mismatches are retried a bounded number of times and a
// nibble that never agrees is committed from its last execution with out_err set.
module addr4u_nibble_seq
  import addr4u_pkg::*;
#(
  parameter int NIBBLES   = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLES*NIBBLE_W-1:0] in_a,
  input  logic [NIBBLES*NIBBLE_W-1:0] in_b,
  input  logic                        in_cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLES*NIBBLE_W-1:0] out_sum,
  output logic                        out_cout,
  output logic                        out_err,
  output logic [NIBBLE_W-1:0]         add_a,
  output logic [NIBBLE_W-1:0]         add_b,
  output logic                        add_cin,
  input  logic [NIBBLE_W-1:0]         add_s,
  input  logic                        add_cout
);

  localparam int W  = NIBBLES * NIBBLE_W;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int RW = retry_w(MAX_RETRY);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NIBBLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t              state_reg, state_next;
  logic [W-1:0]        a_reg, a_next;
  logic [W-1:0]        b_reg, b_next;
  logic [W-1:0]        sum_reg, sum_next;
  logic [IW-1:0]       idx_reg, idx_next;
  logic [RW-1:0]       retry_reg, retry_next;
  logic [NIBBLE_W:0]   r1_reg, r1_next;
  logic                carry_reg, carry_next;
  logic                cout_reg, cout_next;
  logic                err_reg, err_next;
  logic [NIBBLE_W:0]   res;
  logic                exec;

  assign exec = (state_reg == EXEC1) || (state_reg == EXEC2);
  assign res  = {add_cout, add_s};

  addr4u_nibble_mux #(
    .NIBBLES(NIBBLES),
    .IW     (IW)
  ) u_mux (
    .a    (a_reg),
    .b    (b_reg),
    .idx  (idx_reg),
    .swap (state_reg == EXEC2),
    .en   (exec),
    .add_a(add_a),
    .add_b(add_b)
  );

  // Register all sequencer state; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      idx_reg   <= '0;
      retry_reg <= '0;
      r1_reg    <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      idx_reg   <= idx_next;
      retry_reg <= retry_next;
      r1_reg    <= r1_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      err_reg   <= err_next;
    end
  end

  // Next-state, redundant compare, retry bookkeeping and nibble commit.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    idx_next   = idx_reg;
    retry_next = retry_reg;
    r1_next    = r1_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_next     = in_a;
          b_next     = in_b;
          carry_next = in_cin;
          err_next   = 1'b0;
          idx_next   = '0;
          retry_next = '0;
          state_next = EXEC1;
        end
      end
      EXEC1: begin
        r1_next    = res;
        state_next = EXEC2;
      end
      EXEC2: begin
        if ((res == r1_reg) || (retry_reg == RETRY_MAX)) begin
          // Agreement, or retries exhausted: the second execution is committed.
          if (res != r1_reg) begin
            err_next = 1'b1;
          end
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_reg == IW'(i)) begin
              sum_next[i*NIBBLE_W +: NIBBLE_W] = add_s;
            end
          end
          carry_next = add_cout;
          retry_next = '0;
          if (idx_reg == LAST_IDX) begin
            cout_next  = add_cout;
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + IW'(1);
            state_next = EXEC1;
          end
        end else begin
          retry_next = retry_reg + RW'(1);
          state_next = EXEC1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
  assign out_err   = err_reg;
  assign add_cin   = exec & carry_reg;

endmodule

// File: tb/tb_addr4u_nibble_seq.sv
// Bench for addr4u_nibble_seq: a 4-nibble instance with a fault-injecting slice
// model and a 1-nibble instance swept exhaustively, both checked via scoreboards.
module tb_addr4u_nibble_seq;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // 4-nibble instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_err;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_s;
  logic        add_cout;

  // 1-nibble instance
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [3:0]  s_in_a = '0;
  logic [3:0]  s_in_b = '0;
  logic        s_in_cin = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [3:0]  s_out_sum;
  logic        s_out_cout;
  logic        s_out_err;
  logic [3:0]  s_add_a;
  logic [3:0]  s_add_b;
  logic        s_add_cin;
  logic [3:0]  s_add_s;
  logic        s_add_cout;

  int          n_chk = 0;
  int          n_pass = 0;
  int          step = -1;
  int          fault_mode = 0;
  logic        fault_hit;
  logic [4:0]  true_res;
  logic [4:0]  s_res;

  exp_t        sb[$];
  logic [4:0]  s_sb[$];

  always #5 clk = ~clk;

  addr4u_nibble_seq #(.NIBBLES(4), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .out_err(out_err), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  addr4u_nibble_seq #(.NIBBLES(1), .MAX_RETRY(0)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum), .out_cout(s_out_cout),
    .out_err(s_out_err), .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin),
    .add_s(s_add_s), .add_cout(s_add_cout)
  );

  // Slice model: step counts cycles since acceptance, fault modes flip add_s[0].
  // Mode 1: first EXEC1 of nibble 2 (step 4). Mode 2: every EXEC2 of nibble 1 (steps 3,5,7).
  always_comb begin
    fault_hit = ((fault_mode == 1) && (step == 4)) ||
                ((fault_mode == 2) && ((step == 3) || (step == 5) || (step == 7)));
    true_res  = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    add_cout  = true_res[4];
    add_s     = true_res[3:0] ^ {3'b000, fault_hit};
  end

  // Fault-free slice for the 1-nibble instance.
  always_comb begin
    s_res      = {1'b0, s_add_a} + {1'b0, s_add_b} + {4'b0, s_add_cin};
    s_add_s    = s_res[3:0];
    s_add_cout = s_res[4];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the 4-nibble instance; hold>0 keeps out_ready low that many cycles.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input int fmode, input int hold);
    exp_t        e;
    logic [16:0] full;
    int          lat;
    full   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.err  = 1'b0;
    e.lat  = 8;
    if (fmode == 1) e.lat = 10;
    if (fmode == 2) begin
      e.lat = 12;
      e.err = 1'b1;
      e.sum = e.sum ^ 16'h0010;
    end
    sb.push_back(e);
    step       = -1;
    fault_mode = fmode;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) tick();
    chk("accept_ready", in_ready, 1'b1);
    tick();
    step = 0;
    in_valid = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_cin = ~cin;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      step++;
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("sum", out_sum, e.sum);
    chk("cout", out_cout, e.cout);
    chk("err", out_err, e.err);
    chk("done_in_ready", in_ready, 1'b0);
    chk("done_slice_idle", {add_a, add_b, add_cin}, 9'd0);
    $display("txn a=%h b=%h cin=%0d fault=%0d sum=%h cout=%0d err=%0d lat=%0d",
             a, b, cin, fmode, out_sum, out_cout, out_err, lat);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      tick();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_sum", out_sum, e.sum);
      chk("hold_err", out_err, e.err);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 1'b0);
    if (hold > 0) chk("ready_after_drain", in_ready, 1'b1);
    in_valid   = 1'b0;
    fault_mode = 0;
  endtask

  // One transaction on the 1-nibble instance.
  task automatic run_small(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] e;
    int         lat;
    s_sb.push_back({1'b0, a} + {1'b0, b} + {4'b0, cin});
    s_in_a = a; s_in_b = b; s_in_cin = cin; s_in_valid = 1'b1;
    for (int k = 0; k < 10 && !s_in_ready; k++) tick();
    tick();
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    e = s_sb.pop_front();
    chk("sweep_res", {s_out_cout, s_out_sum}, e);
    chk("sweep_lat", lat, 2);
    chk("sweep_err", s_out_err, 1'b0);
    $display("txn1 a=%h b=%h cin=%0d res=%h lat=%0d", a, b, cin, {s_out_cout, s_out_sum}, lat);
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
  endtask

  initial begin
    logic [8:0] v9;
    // Reset state while rst is held high.
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", {out_sum, out_cout, out_err}, 18'd0);
    chk("rst_slice", {add_a, add_b, add_cin}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1'b1);

    // Fault-free carry ripple through every nibble.
    run_txn(16'hFFFF, 16'h0001, 1'b0, 0, 0);
    // Single transient fault on nibble 2 EXEC1: one retry.
    run_txn(16'h1234, 16'h4321, 1'b1, 1, 0);
    // Persistent EXEC2 fault on nibble 1: retries exhausted.
    run_txn(16'h1234, 16'h4321, 1'b0, 2, 0);
    // Error flag must clear on the next clean transaction.
    run_txn(16'h8000, 16'h8000, 1'b0, 0, 0);
    // Backpressure with an intruding in_valid.
    run_txn(16'hABCD, 16'h1111, 1'b1, 0, 5);
    for (int r = 0; r < 3; r++) run_txn(16'($urandom), 16'($urandom), 1'($urandom), 0, 0);

    // Reset during EXEC2 of nibble 1.
    in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) tick();
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_outputs", {out_sum, out_cout, out_err}, 18'd0);
    chk("abort_slice", {add_a, add_b, add_cin}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("abort_idle_ready", in_ready, 1'b1);
    run_txn(16'h000F, 16'h0001, 1'b0, 0, 0);

    // Exhaustive sweep of the 1-nibble, no-retry instance.
    for (int v = 0; v < 512; v++) begin
      v9 = 9'(v);
      run_small(v9[3:0], v9[7:4], v9[8]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/addr4u_nibble_seq.md
Name: addr4u_nibble_seq

Overview:
- Sequencer that performs wide unsigned additions by time-multiplexing one shared 4-bit adder slice, one nibble per step, LSB nibble first.
- Carry is rippled between steps.
- Each nibble is executed twice for temporal redundancy: first a+b, then b+a. Mismatches trigger bounded retries.
- Sits between a valid/ready requester and a fault-resilient 4-bit adder slice.

Parameters:
- NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES); legal range 1..8.
- MAX_RETRY, 2, retries allowed per nibble after a mismatch; legal range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  initial carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  W  sum.
- out_cout  out  1  final carry-out.
- out_err  out  1  at least one nibble exhausted its retries in this transaction.
- add_a  out  4  adder slice operand 1.
- add_b  out  4  adder slice operand 2.
- add_cin  out  1  adder slice carry-in.
- add_s  in  4  adder slice sum (combinational response, same cycle).
- add_cout  in  1  adder slice carry-out.

Behaviour:
- Reset values: in_ready=0 while rst is high, 1 in the first IDLE cycle after release. out_valid=0, out_sum=0, out_cout=0, out_err=0, add_a=add_b=0, add_cin=0. State IDLE, nibble index 0, retry count 0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_a, in_b and in_cin, clear out_err, set idx=0 and carry=in_cin, then go to EXEC1.
  - EXEC1: drive add_a=A[idx], add_b=B[idx], add_cin=carry. Capture {add_cout,add_s} into r1, then go to EXEC2.
  - EXEC2: drive add_a=B[idx], add_b=A[idx], add_cin=carry. Compare {add_cout,add_s} with r1.
    - Match: commit sum nibble idx and set carry=add_cout. Clear the retry count. If idx==NIBBLES-1, go to DONE; else idx+1 and go to EXEC1.
    - Mismatch with retry count < MAX_RETRY: increment the retry count, return to EXEC1 with the same idx. Carry is unchanged.
    - Mismatch with retry count == MAX_RETRY: set out_err (sticky for this transaction). Commit the EXEC2 result, then continue as for a match.
  - DONE: out_valid=1; out_sum, out_cout and out_err are stable. On out_ready, go to IDLE.
- in_ready is low in DONE, so there is no same-cycle accept-on-drain. A new request is taken one cycle after out_ready.
- Latency: acceptance edge to out_valid high.
  - Fault-free: 2*NIBBLES cycles.
  - Each retry adds 2 cycles.
  - Worst case: 2*NIBBLES*(1+MAX_RETRY).
- add_a, add_b and add_cin are 0 outside EXEC1/EXEC2.
- Width rule: out_sum and out_cout together equal in_a+in_b+in_cin, modulo 2^(W+1). The retry count width is clog2(MAX_RETRY+1), minimum 1.
- in_a and in_b may change after acceptance without effect.
- in_valid asserted outside IDLE is ignored.
- Reset asserted mid-operation immediately aborts the transaction. All outputs return to their reset values and the latched operands are discarded.
- out_ready asserted while not in DONE has no effect.

Decomposition:
- Shared package addr4u_pkg holds:
  - state enum: IDLE, EXEC1, EXEC2, DONE;
  - NIBBLE_W=4 constant;
  - retry-count width function.
- Sub-module addr4u_nibble_mux:
  - selects nibble idx of A and B;
  - applies the EXEC2 operand swap.
- The FSM, commit register and compare logic live in the top module.

Test Plan:
- Fault-free, NIBBLES=4: A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x0000, out_cout=1, out_err=0, out_valid high 8 cycles after acceptance.
- Bench adder model flips add_s[0] on the first EXEC1 of nibble 2 only. A=0x1234, B=0x4321, cin=1 -> out_sum=0x5556, out_cout=0, out_err=0, latency 10 cycles.
- Persistent fault on nibble 1 (add_s XOR 0x1 in EXEC2 only), MAX_RETRY=2 -> latency 12 cycles, out_err=1, nibble 1 of out_sum = EXEC2 value.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_err stable. in_ready stays 0; a new in_valid is not accepted until the cycle after the out_ready handshake.
- Assert rst during EXEC2 of nibble 1 -> all outputs 0 asynchronously. After release, in_ready=1, and the next transaction (A=0x000F, B=0x0001) gives 0x0010.
- Exhaustive sweep, NIBBLES=1, MAX_RETRY=0: all 512 combinations of A, B and cin -> {out_cout,out_sum}=A+B+cin, latency 2 cycles each.
